// File: rtl/output_vc_controller_pkg.sv
// Shared network parameters, flit-type codes and helpers for the output VC controller.
// The legacy `V/`N/`DW/`HEAD/`BODY/`TAIL/`BUF_DEPTH macros stay defined for older includers.
`ifndef OUTPUT_VC_CONTROLLER_PARAMS
`define OUTPUT_VC_CONTROLLER_PARAMS
`define V         4
`define N         5
`define DW        32
`define HEAD      2'b01
`define BODY      2'b10
`define TAIL      2'b11
`define BUF_DEPTH 4
`endif

package output_vc_controller_pkg;
  localparam int unsigned V         = `V;
  localparam int unsigned N         = `N;
  localparam int unsigned DW        = `DW;
  localparam int unsigned BUF_DEPTH = `BUF_DEPTH;

  localparam logic [1:0] FT_HEAD = `HEAD;
  localparam logic [1:0] FT_BODY = `BODY;
  localparam logic [1:0] FT_TAIL = `TAIL;

  function automatic logic onehot_v(input logic [V-1:0] x);
    return (x != '0) && ((x & (x - V'(1))) == '0);
  endfunction
endpackage

// File: rtl/output_vc_controller_ovc_state.sv
// One output VC: IDLE/ACTIVE/DRAIN state, downstream credit counter, owning input port
// and a sticky per-VC protocol-error bit.
module ovc_state
  import output_vc_controller_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc,
  input  logic [N-1:0] alloc_port,
  input  logic         flit,
  input  logic         flit_tail,
  input  logic         credit,
  output logic         idle,
  output logic         ready,
  output logic [N-1:0] owner,
  output logic         err
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  owner_nxt;
  logic          err_evt;

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    owner_nxt = owner;
    err_evt   = 1'b0;

    // Flit and credit together cancel; each alone saturates at its bound.
    if (flit && !credit) begin
      if (cnt == '0) err_evt = 1'b1;
      else           cnt_nxt = cnt - CW'(1);
    end else if (credit && !flit) begin
      if (cnt == FULL) err_evt = 1'b1;
      else             cnt_nxt = cnt + CW'(1);
    end

    if (flit && state == ST_IDLE) err_evt = 1'b1;

    // An allocation (legal or not) blocks the tail transition in the same cycle.
    if (alloc) begin
      if (state == ST_IDLE) begin
        state_nxt = ST_ACTIVE;
        owner_nxt = alloc_port;
      end else begin
        err_evt = 1'b1;
      end
      if (flit_tail) err_evt = 1'b1;
    end else begin
      case (state)
        ST_IDLE:   ;
        ST_ACTIVE: if (flit_tail) state_nxt = (cnt_nxt == FULL) ? ST_IDLE : ST_DRAIN;
        ST_DRAIN:  if (cnt_nxt == FULL) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end

    if (state_nxt == ST_IDLE) owner_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= FULL;
      owner <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      err   <= err | err_evt;
    end
  end

  assign idle  = (state == ST_IDLE);
  assign ready = (cnt != '0);
endmodule

// File: rtl/output_vc_controller.sv
// Output-port VC controller: per-VC state/credit tracking plus one-hot input screening.
module output_vc_controller
  import output_vc_controller_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vaValid,
  input  logic [V-1:0]   vaVC,
  input  logic [N-1:0]   vaInPort,
  input  logic           flitValid,
  input  logic [V-1:0]   flitVC,
  input  logic [1:0]     flitType,
  input  logic           creditValid,
  input  logic [V-1:0]   creditVC,
  output logic [V-1:0]   readyVC,
  output logic [V-1:0]   idleVC,
  output logic [N*V-1:0] ownerPort,
  output logic           err
);
  logic         va_ok, flit_ok, credit_ok, oh_bad, oh_err;
  logic         is_tail;
  logic [V-1:0] vc_err;

  assign va_ok     = vaValid     && onehot_v(vaVC);
  assign flit_ok   = flitValid   && onehot_v(flitVC);
  assign credit_ok = creditValid && onehot_v(creditVC);
  assign oh_bad    = (vaValid && !va_ok) || (flitValid && !flit_ok) || (creditValid && !credit_ok);
  assign is_tail   = (flitType == FT_TAIL);

  for (genvar v = 0; v < V; v++) begin : g_vc
    ovc_state #(.DEPTH(DEPTH)) u_ovc (
      .clk        (clk),
      .rst        (rst),
      .alloc      (va_ok && vaVC[v]),
      .alloc_port (vaInPort),
      .flit       (flit_ok && flitVC[v]),
      .flit_tail  (flit_ok && flitVC[v] && is_tail),
      .credit     (credit_ok && creditVC[v]),
      .idle       (idleVC[v]),
      .ready      (readyVC[v]),
      .owner      (ownerPort[v*N +: N]),
      .err        (vc_err[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) oh_err <= 1'b0;
    else     oh_err <= oh_err | oh_bad;
  end

  assign err = oh_err | (|vc_err);
endmodule
